// File: rtl/get_enable_fifo.sv
// ----------------------------------------------------------------------------
// get_enable_fifo
//
// Gated host->core word buffer. Words are accepted from the host stream only
// while the block is running and not in its generation phase, held in a
// DEPTH-entry FIFO, and offered to the core as an exec/exec_ready stream. Each
// delivered word carries a round-robin channel tag. Delivered words are
// counted against a programmable target, and a single-cycle done pulse marks
// the moment the target is reached.
//
// Parameters
//   DW     data width of get_data / exec_data
//   DEPTH  FIFO entries (power of 2, >= 2)
//   NCH    channel count used for exec_ch tagging (>= 1)
//   CNT_W  width of the delivered-word counter and of target
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   run         block enable; low flushes the FIFO, tag and counter
//   gen         generation phase; high blocks new input
//   get_valid   host word valid
//   get_data    host word
//   get_ready   block accepts a word this cycle
//   exec        exec_data / exec_ch valid towards the core
//   exec_data   word at the head of the FIFO
//   exec_ch     channel tag of the head word
//   exec_ready  core consumes the head word
//   target      words expected per run; 0 disables done
//   cnt         words delivered since the last flush (saturating)
//   done        one-cycle pulse after the pop that makes cnt == target
// ----------------------------------------------------------------------------
module get_enable_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             gen,
  input  logic             get_valid,
  input  logic [DW-1:0]    get_data,
  output logic             get_ready,
  output logic             exec,
  output logic [DW-1:0]    exec_data,
  output logic [CHW-1:0]   exec_ch,
  input  logic             exec_ready,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_OCC = (AW + 1)'(DEPTH);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NCH - 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Round-robin channel advance; a single channel always stays at tag 0.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    if (NCH == 1)
      next_ch = '0;
    else if (c == LAST_CH)
      next_ch = '0;
    else
      next_ch = c + CHW'(1);
  endfunction

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_inc;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);

  // Handshakes. run gates both sides combinationally so a falling run stops
  // traffic in the same cycle; the flush then happens on the next edge. rst
  // also gates get_ready so nothing is offered while the block is held reset.
  // No full-bypass: a full FIFO refuses input even if a pop happens this cycle.
  assign get_ready = ~rst & run & ~gen & ~full;
  assign exec      = run & ~empty;
  assign push      = get_valid & get_ready;
  assign pop       = exec & exec_ready;

  // The head word sits still until popped: writes only target wr_ptr, which
  // never equals rd_ptr while the FIFO holds at least one word and has room.
  assign exec_data = mem[rd_ptr];

  assign cnt_inc = sat_inc(cnt);

  // ---- storage stage: data array, written on push, never reset ----
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= get_data;
  end

  // ---- control stage: pointers, occupancy, tag, counter, done ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      exec_ch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else if (!run) begin
      // Synchronous flush: buffered words are discarded.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      exec_ch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);

      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        exec_ch <= next_ch(exec_ch);
        cnt     <= cnt_inc;
      end

      case ({push, pop})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase

      // Pulse only on the transition into cnt == target; once saturated at a
      // target of all-ones, further pops keep cnt equal but must not re-fire.
      done <= pop && (target != '0) && (cnt_inc == target) && (cnt != target);
    end
  end

endmodule

// File: tb/tb_get_enable_fifo.sv
module tb_get_enable_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             run;
  logic             gen;
  logic             get_valid;
  logic [DW-1:0]    get_data;
  logic             get_ready;
  logic             exec;
  logic [DW-1:0]    exec_data;
  logic [1:0]       exec_ch;
  logic             exec_ready;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt;
  logic             done;

  get_enable_fifo #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .gen(gen),
    .get_valid(get_valid), .get_data(get_data), .get_ready(get_ready),
    .exec(exec), .exec_data(exec_data), .exec_ch(exec_ch),
    .exec_ready(exec_ready), .target(target), .cnt(cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             run;
    logic             gen;
    logic             vld;
    logic [DW-1:0]    data;
    logic             erdy;
    logic [CNT_W-1:0] tgt;
    logic             e_gr;
    logic             e_exec;
    logic [1:0]       e_ch;
    logic [CNT_W-1:0] e_cnt;
    logic             e_done;
  } vec_t;

  int checks;
  int failures;
  int dut_pops;

  // Reference model: scoreboard queue of words in flight plus tag/count state.
  logic [DW-1:0]    mq[$];
  logic [1:0]       m_ch;
  logic [CNT_W-1:0] m_cnt;
  logic             m_done;
  logic             m_fired;

  function automatic vec_t vec(input logic r, input logic g, input logic v,
                               input logic [DW-1:0] d, input logic er,
                               input logic [CNT_W-1:0] tg, input logic egr,
                               input logic eex, input logic [1:0] ech,
                               input logic [CNT_W-1:0] ecnt, input logic edn);
    vec_t x;
    x.run = r; x.gen = g; x.vld = v; x.data = d; x.erdy = er; x.tgt = tg;
    x.e_gr = egr; x.e_exec = eex; x.e_ch = ech; x.e_cnt = ecnt; x.e_done = edn;
    return x;
  endfunction

  function automatic vec_t inp(input logic r, input logic g, input logic v,
                               input logic [DW-1:0] d, input logic er,
                               input logic [CNT_W-1:0] tg);
    return vec(r, g, v, d, er, tg, 1'b0, 1'b0, 2'd0, '0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    mq.delete();
    m_ch    = '0;
    m_cnt   = '0;
    m_done  = 1'b0;
    m_fired = 1'b0;
  endtask

  // One clock cycle: drive after the falling edge, check mid-low-phase,
  // advance the model across the rising edge, return on the next falling edge.
  task automatic step(input vec_t v, input bit use_tbl);
    logic exp_gr, exp_ex, do_push, do_pop, nd;
    run = v.run; gen = v.gen; get_valid = v.vld; get_data = v.data;
    exec_ready = v.erdy; target = v.tgt;
    #1;
    exp_gr = v.run && !v.gen && (mq.size() < DEPTH);
    exp_ex = v.run && (mq.size() != 0);
    chk("get_ready", get_ready, exp_gr);
    chk("exec", exec, exp_ex);
    chk("exec_ch", exec_ch, m_ch);
    chk("cnt", cnt, m_cnt);
    chk("done", done, m_done);
    if (exp_ex) chk("exec_data", exec_data, mq[0]);
    if (use_tbl) begin
      chk("tbl_get_ready", get_ready, v.e_gr);
      chk("tbl_exec", exec, v.e_exec);
      chk("tbl_exec_ch", exec_ch, v.e_ch);
      chk("tbl_cnt", cnt, v.e_cnt);
      chk("tbl_done", done, v.e_done);
    end
    if (exec && exec_ready) dut_pops++;
    @(posedge clk);
    if (!v.run) begin
      m_clear();
    end else begin
      do_push = v.vld && exp_gr;
      do_pop  = exp_ex && v.erdy;
      nd = 1'b0;
      if (do_pop) begin
        void'(mq.pop_front());
        m_ch = (m_ch == 2'(NCH - 1)) ? 2'd0 : m_ch + 2'd1;
        if (m_cnt != CNT_W'(CNT_MAX)) m_cnt = m_cnt + 1'b1;
        if (v.tgt != 0 && m_cnt == v.tgt && !m_fired) begin
          nd = 1'b1;
          m_fired = 1'b1;
        end
      end
      if (do_push) mq.push_back(v.data);
      m_done = nd;
    end
    @(negedge clk);
  endtask

  vec_t tbl[21];

  initial begin
    int pushed;
    logic [DW-1:0] d;
    logic er;
    checks = 0; failures = 0; dut_pops = 0;
    m_clear();

    // rows: run gen vld data erdy target | get_ready exec ch cnt done
    tbl[0]  = vec(1,0,1,32'hA5, 0,0, 1,0,0,0,0);
    tbl[1]  = vec(1,0,0,32'h0,  1,0, 1,1,0,0,0);
    tbl[2]  = vec(1,0,0,32'h0,  0,0, 1,0,1,1,0);
    tbl[3]  = vec(0,0,0,32'h0,  0,0, 0,0,1,1,0);
    tbl[4]  = vec(1,0,1,32'h11, 0,0, 1,0,0,0,0);
    tbl[5]  = vec(1,0,1,32'h22, 0,0, 1,1,0,0,0);
    tbl[6]  = vec(1,0,1,32'h33, 0,0, 1,1,0,0,0);
    tbl[7]  = vec(1,0,1,32'h44, 0,0, 1,1,0,0,0);
    tbl[8]  = vec(1,0,1,32'h55, 0,0, 0,1,0,0,0);
    tbl[9]  = vec(1,0,1,32'h66, 1,0, 0,1,0,0,0);
    tbl[10] = vec(1,0,0,32'h0,  1,0, 1,1,1,1,0);
    tbl[11] = vec(1,0,0,32'h0,  1,0, 1,1,2,2,0);
    tbl[12] = vec(1,0,0,32'h0,  1,0, 1,1,3,3,0);
    tbl[13] = vec(1,0,0,32'h0,  1,0, 1,0,0,4,0);
    tbl[14] = vec(0,0,0,32'h0,  0,0, 0,0,0,4,0);
    tbl[15] = vec(1,0,1,32'h101,1,3, 1,0,0,0,0);
    tbl[16] = vec(1,0,1,32'h102,1,3, 1,1,0,0,0);
    tbl[17] = vec(1,0,1,32'h103,1,3, 1,1,1,1,0);
    tbl[18] = vec(1,0,1,32'h104,1,3, 1,1,2,2,0);
    tbl[19] = vec(1,0,0,32'h0,  1,3, 1,1,3,3,1);
    tbl[20] = vec(1,0,0,32'h0,  1,3, 1,0,0,4,0);

    // Reset with run already high: nothing may be offered or presented.
    rst = 1'b1; run = 1'b1; gen = 1'b0; get_valid = 1'b1; get_data = 32'h5A;
    exec_ready = 1'b1; target = '0;
    #3;
    chk("rst_get_ready", get_ready, 1'b0);
    chk("rst_exec", exec, 1'b0);
    chk("rst_exec_ch", exec_ch, 2'd0);
    chk("rst_cnt", cnt, 8'd0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) step(tbl[i], 1'b1);

    // gen high with two words buffered: input blocked, output drains.
    step(inp(0,0,0,32'h0,0,0), 1'b0);
    step(inp(1,0,1,32'hB1,0,0), 1'b0);
    step(inp(1,0,1,32'hB2,0,0), 1'b0);
    step(inp(1,1,1,32'hB3,0,0), 1'b0);
    step(inp(1,1,1,32'hB4,1,0), 1'b0);
    step(inp(1,1,1,32'hB5,1,0), 1'b0);
    step(inp(1,1,0,32'h0,1,0), 1'b0);
    step(inp(1,0,1,32'hB6,0,0), 1'b0);
    step(inp(1,0,0,32'h0,1,0), 1'b0);

    // run low with three words buffered and a nonzero tag/count.
    step(inp(1,0,1,32'hC1,0,0), 1'b0);
    step(inp(1,0,1,32'hC2,0,0), 1'b0);
    step(inp(1,0,1,32'hC3,0,0), 1'b0);
    step(inp(1,0,1,32'hC4,1,0), 1'b0);
    step(inp(0,0,1,32'hC5,1,0), 1'b0);
    step(inp(1,0,0,32'h0,1,0), 1'b0);

    // Asynchronous reset in the middle of a burst.
    step(inp(1,0,1,32'hD1,0,0), 1'b0);
    step(inp(1,0,1,32'hD2,0,0), 1'b0);
    run = 1'b1; gen = 1'b0; get_valid = 1'b1; get_data = 32'hD3; exec_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_get_ready", get_ready, 1'b0);
    chk("arst_exec", exec, 1'b0);
    chk("arst_exec_ch", exec_ch, 2'd0);
    chk("arst_cnt", cnt, 8'd0);
    chk("arst_done", done, 1'b0);
    m_clear();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dut_pops = 0;
    step(inp(1,0,0,32'h0,1,0), 1'b0);

    // Full-rate streaming of 1000 uniquely tagged words; counter saturates.
    pushed = 0;
    for (int i = 0; i < 4000 && pushed < 1000; i++) begin
      d  = {pushed[11:0], 20'($urandom)};
      er = (pushed < 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mq.size() < DEPTH) pushed++;
      step(inp(1,0,1,d,er,8'd255), 1'b0);
    end
    for (int i = 0; i < 8; i++) step(inp(1,0,0,32'h0,1,8'd255), 1'b0);
    chk("stream_pushed", pushed, 1000);
    chk("stream_delivered", dut_pops, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
